st_push_pop_sequencer: RTL and testbench

Multi-cycle executor for Thumb PUSH/POP register-list instructions in the stack unit, sitting behind the stack-instruction decoder and in front of the data-memory port and register file. It accepts one instruction per handshake and expands it into one memory transfer per listed register. It tracks the running stack address and writes the final SP back on completion. Word width and address width are parametrised, so the same block serves 32-bit and 64-bit datapaths.

---
 rtl/st_push_pop_sequencer_if.sv | 43 ++++
 rtl/st_push_pop_sequencer.sv | 153 +++++++++++++++
 tb/tb_st_push_pop_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/st_push_pop_sequencer_if.sv
// Bundle of the instruction handshake, register-file and data-memory signals
// of the PUSH/POP sequencer.
//   slave  : sequencer view (takes instructions, drives memory/regfile requests)
//   master : environment view (issues instructions, answers memory/regfile)
// Signals: inst_in/inst_valid/inst_ready/sp_in (instruction accept),
//   reg_rd_idx/reg_rd_data (PUSH data read), mem_* (data-memory port),
//   reg_wr_* (POP writeback), sp_wr_* / busy / done (completion).
interface st_push_pop_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [15:0]       inst_in;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] sp_in;
  logic [3:0]        reg_rd_idx;
  logic [DATA_W-1:0] reg_rd_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              reg_wr_en;
  logic [3:0]        reg_wr_idx;
  logic [DATA_W-1:0] reg_wr_data;
  logic              sp_wr_en;
  logic [ADDR_W-1:0] sp_wr_data;
  logic              busy;
  logic              done;

  modport slave (
    input  inst_in, inst_valid, sp_in, reg_rd_data, mem_ack, mem_rdata,
    output inst_ready, reg_rd_idx, mem_req, mem_we, mem_addr, mem_wdata,
           reg_wr_en, reg_wr_idx, reg_wr_data, sp_wr_en, sp_wr_data, busy, done
  );

  modport master (
    output inst_in, inst_valid, sp_in, reg_rd_data, mem_ack, mem_rdata,
    input  inst_ready, reg_rd_idx, mem_req, mem_we, mem_addr, mem_wdata,
           reg_wr_en, reg_wr_idx, reg_wr_data, sp_wr_en, sp_wr_data, busy, done
  );
endinterface

// File: rtl/st_push_pop_sequencer.sv
// Multi-cycle executor for Thumb PUSH/POP register-list instructions.
// Accepts one instruction per handshake, expands it into one memory transfer
// per listed register (ascending register order, ascending addresses), and
// writes the final SP back with a one-cycle done pulse.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : st_push_pop_sequencer_if.slave (instruction, memory, regfile, SP)
module st_push_pop_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic                    clk,
  input logic                    reset,
  st_push_pop_sequencer_if.slave bus
);

  localparam int unsigned Stride = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic              op_push_q, op_push_d;
  logic [15:0]       mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] final_sp_q, final_sp_d;
  logic              reg_wr_en_q, reg_wr_en_d;
  logic [3:0]        reg_wr_idx_q, reg_wr_idx_d;
  logic [DATA_W-1:0] reg_wr_data_q, reg_wr_data_d;

  logic              is_push, is_pop;
  logic [15:0]       new_mask;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] span;
  logic [3:0]        cur_idx;
  logic              is_last;
  logic              xfer;

  // Instruction decode: R selects LR for PUSH and PC for POP.
  always_comb begin
    is_push       = (bus.inst_in[15:9] == 7'b1011010);
    is_pop        = (bus.inst_in[15:9] == 7'b1011110);
    new_mask      = '0;
    new_mask[7:0] = bus.inst_in[7:0];
    if (is_push) begin
      new_mask[14] = bus.inst_in[8];
    end else begin
      new_mask[15] = bus.inst_in[8];
    end
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {3'b000, new_mask[i]};
    end
    span = ADDR_W'(cnt) * ADDR_W'(Stride);
  end

  // Current register is the lowest pending bit.
  always_comb begin
    cur_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) begin
        cur_idx = 4'(i);
      end
    end
    is_last = ((mask_q & (mask_q - 16'd1)) == 16'd0);
  end

  always_comb begin
    state_d       = state_q;
    op_push_d     = op_push_q;
    mask_d        = mask_q;
    addr_d        = addr_q;
    final_sp_d    = final_sp_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_idx_d  = '0;
    reg_wr_data_d = '0;
    unique case (state_q)
      StIdle: begin
        // Non-stack instructions are consumed silently.
        if (bus.inst_valid && (is_push || is_pop)) begin
          op_push_d = is_push;
          mask_d    = new_mask;
          if (is_push) begin
            addr_d     = bus.sp_in - span;
            final_sp_d = bus.sp_in - span;
          end else begin
            addr_d     = bus.sp_in;
            final_sp_d = bus.sp_in + span;
          end
          state_d = (cnt == 4'd0) ? StDone : StXfer;
        end
      end
      StXfer: begin
        if (bus.mem_ack) begin
          mask_d[cur_idx] = 1'b0;
          addr_d          = addr_q + ADDR_W'(Stride);
          if (!op_push_q) begin
            reg_wr_en_d   = 1'b1;
            reg_wr_idx_d  = cur_idx;
            reg_wr_data_d = bus.mem_rdata;
          end
          if (is_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      op_push_q     <= 1'b0;
      mask_q        <= '0;
      addr_q        <= '0;
      final_sp_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_idx_q  <= '0;
      reg_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      op_push_q     <= op_push_d;
      mask_q        <= mask_d;
      addr_q        <= addr_d;
      final_sp_q    <= final_sp_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_idx_q  <= reg_wr_idx_d;
      reg_wr_data_q <= reg_wr_data_d;
    end
  end

  assign xfer            = (state_q == StXfer);
  assign bus.inst_ready  = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.mem_req     = xfer;
  assign bus.mem_we      = xfer & op_push_q;
  assign bus.mem_addr    = xfer ? addr_q : '0;
  assign bus.reg_rd_idx  = xfer ? cur_idx : '0;
  assign bus.mem_wdata   = (xfer && op_push_q) ? bus.reg_rd_data : '0;
  assign bus.reg_wr_en   = reg_wr_en_q;
  assign bus.reg_wr_idx  = reg_wr_idx_q;
  assign bus.reg_wr_data = reg_wr_data_q;
  assign bus.sp_wr_en    = (state_q == StDone);
  assign bus.done        = (state_q == StDone);
  assign bus.sp_wr_data  = (state_q == StDone) ? final_sp_q : '0;

endmodule

// File: tb/tb_st_push_pop_sequencer.sv
module tb_st_push_pop_sequencer;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } rw_t;

  typedef struct {
    logic [31:0] sp;
    int          cyc;
  } sp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   ack_pct;
  int   stall_left;

  logic [31:0] rf [16];

  mem_t exp_mem[$];
  rw_t  exp_reg[$];
  sp_t  exp_sp[$];

  st_push_pop_sequencer_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  st_push_pop_sequencer_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  st_push_pop_sequencer #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus32.slave)
  );

  st_push_pop_sequencer #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus64.slave)
  );

  // Read-only memory image: two fixed words, a hash elsewhere.
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0FF8: return 32'hAAAA_0001;
      32'h0000_0FFC: return 32'hBBBB_0002;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  assign bus32.reg_rd_data = rf[bus32.reg_rd_idx];
  assign bus32.mem_rdata   = memf(bus32.mem_addr);
  assign bus64.reg_rd_data = {rf[bus64.reg_rd_idx], ~rf[bus64.reg_rd_idx]};
  assign bus64.mem_rdata   = '0;
  assign bus64.mem_ack     = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Cycle counter and memory ack driver (ack decided just after each edge).
  initial begin
    cyc = 0;
    bus32.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (stall_left > 0 && bus32.mem_req) begin
        bus32.mem_ack = 1'b0;
        stall_left--;
      end else begin
        bus32.mem_ack = ($urandom_range(0, 99) < ack_pct);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    bit          pend;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    mem_t        m;
    rw_t         r;
    sp_t         s;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("stall_req_held", bus32.mem_req, 1);
          chk("stall_addr_stable", bus32.mem_addr, p_addr);
          chk("stall_we_stable", bus32.mem_we, p_we);
          chk("stall_wdata_stable", bus32.mem_wdata, p_wdata);
        end
        pend    = bus32.mem_req && !bus32.mem_ack;
        p_addr  = bus32.mem_addr;
        p_we    = bus32.mem_we;
        p_wdata = bus32.mem_wdata;
        if (bus32.mem_req && !bus32.mem_we) chk("load_wdata_zero", bus32.mem_wdata, 0);
        if (bus32.mem_req && bus32.mem_ack) begin
          if (exp_mem.size() == 0) begin
            chk("unexpected_mem_xfer", 1, 0);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_we", bus32.mem_we, m.we);
            chk("mem_addr", bus32.mem_addr, m.addr);
            chk("mem_wdata", bus32.mem_wdata, m.wdata);
          end
        end
        if (bus32.reg_wr_en) begin
          if (exp_reg.size() == 0) begin
            chk("unexpected_reg_wr", 1, 0);
          end else begin
            r = exp_reg.pop_front();
            chk("reg_wr_idx", bus32.reg_wr_idx, r.idx);
            chk("reg_wr_data", bus32.reg_wr_data, r.data);
          end
        end
        if (bus32.done != bus32.sp_wr_en) chk("done_eq_sp_wr_en", bus32.done, bus32.sp_wr_en);
        if (bus32.sp_wr_en) begin
          if (exp_sp.size() == 0) begin
            chk("unexpected_sp_wr", 1, 0);
          end else begin
            s = exp_sp.pop_front();
            chk("sp_wr_data", bus32.sp_wr_data, s.sp);
            if (s.cyc >= 0) chk("done_cycle", cyc, s.cyc);
          end
        end
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, bus32.inst_ready, 1);
    chk({tag, "_mem"}, {bus32.mem_req, bus32.mem_we, bus32.mem_addr}, 0);
    chk({tag, "_wdata"}, bus32.mem_wdata, 0);
    chk({tag, "_regs"}, {bus32.reg_wr_en, bus32.reg_wr_idx, bus32.reg_rd_idx}, 0);
    chk({tag, "_reg_wr_data"}, bus32.reg_wr_data, 0);
    chk({tag, "_sp"}, {bus32.sp_wr_en, bus32.done, bus32.busy, bus32.sp_wr_data}, 0);
  endtask

  // Drives one instruction at a negedge while idle; queues its expected effects.
  task automatic send(input logic [15:0] inst, input logic [31:0] sp, input bit timed,
                      input int stalls, output int t, output int n, output bit stack);
    bit          push, pop;
    int          regs[$];
    logic [31:0] start, fin, a;
    mem_t        m;
    rw_t         r;
    sp_t         s;
    push  = (inst[15:9] == 7'b1011010);
    pop   = (inst[15:9] == 7'b1011110);
    stack = push || pop;
    t     = cyc;
    for (int k = 0; k < 8; k++) if (inst[k]) regs.push_back(k);
    if (inst[8]) regs.push_back(push ? 14 : 15);
    n = stack ? regs.size() : 0;
    if (stack) begin
      start = push ? sp - 32'(n * 4) : sp;
      fin   = push ? start : sp + 32'(n * 4);
      for (int k = 0; k < n; k++) begin
        a       = start + 32'(k * 4);
        m.we    = push;
        m.addr  = a;
        m.wdata = push ? rf[regs[k]] : 32'h0;
        exp_mem.push_back(m);
        if (pop) begin
          r.idx  = 4'(regs[k]);
          r.data = memf(a);
          exp_reg.push_back(r);
        end
      end
      s.sp  = fin;
      s.cyc = timed ? t + n + 1 + stalls : -1;
      exp_sp.push_back(s);
    end
    bus32.inst_in    = inst;
    bus32.sp_in      = sp;
    bus32.inst_valid = 1'b1;
    @(posedge clk);
    #1;
    bus32.inst_valid = 1'b0;
  endtask

  // Waits (bounded) for inst_ready, optionally driving ignored traffic meanwhile.
  task automatic wait_idle(input int t, input int n, input bit stack, input bit timed,
                           input int stalls, input bit noise);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus32.inst_ready && k < 300) begin
      if (noise) begin
        bus32.inst_valid = 1'($urandom_range(0, 1));
        bus32.inst_in    = 16'($urandom);
        bus32.sp_in      = $urandom;
      end
      @(negedge clk);
      k++;
    end
    bus32.inst_valid = 1'b0;
    chk("ready_within_budget", bus32.inst_ready, 1);
    if (timed) chk("ready_cycle", cyc, stack ? t + n + 2 + stalls : t + 1);
  endtask

  task automatic issue(input logic [15:0] inst, input logic [31:0] sp, input bit timed,
                       input int stalls, input bit noise);
    int t, n;
    bit stack;
    send(inst, sp, timed, stalls, t, n, stack);
    wait_idle(t, n, stack, timed, stalls, noise);
  endtask

  initial begin
    int          t, n;
    bit          stack;
    int          kind;
    logic [15:0] inst;
    logic [31:0] sp;
    n_checks   = 0;
    n_fail     = 0;
    ack_pct    = 100;
    stall_left = 0;
    reset      = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    bus32.inst_in    = '0;
    bus32.inst_valid = 1'b0;
    bus32.sp_in      = '0;
    bus64.inst_in    = '0;
    bus64.inst_valid = 1'b0;
    bus64.sp_in      = '0;
    #1;
    check_reset_outs("reset");
    chk("reset64_ready", bus64.inst_ready, 1);
    chk("reset64_outs", {bus64.mem_req, bus64.done, bus64.busy, bus64.sp_wr_en}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // PUSH {r0, r2, LR}
    issue(16'hB505, 32'h0000_1000, 1, 0, 0);
    // POP {r1, PC}
    issue(16'hBD02, 32'h0000_0FF8, 1, 0, 0);
    // PUSH {r3} with three stall cycles
    stall_left = 3;
    issue(16'hB408, 32'h0000_2000, 1, 3, 0);
    // Non-stack instruction, then empty PUSH
    issue(16'hB004, 32'h0000_0200, 1, 0, 0);
    issue(16'hB400, 32'h0000_0200, 1, 0, 0);

    // POP {r0, r1, r2} abandoned by reset right after its first ack
    send(16'hBC07, 32'h0000_4000, 1, 0, t, n, stack);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("midreset");
    exp_mem.delete();
    exp_reg.delete();
    exp_sp.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_ready", bus32.inst_ready, 1);
    chk("after_reset_no_sp_wr", bus32.sp_wr_en, 0);
    // PUSH {r7}
    issue(16'hB480, 32'h0000_3000, 1, 0, 0);

    // 64-bit datapath: PUSH {r4, r7}
    bus64.inst_in    = 16'hB490;
    bus64.sp_in      = 32'h0000_0100;
    bus64.inst_valid = 1'b1;
    @(posedge clk);
    #1;
    bus64.inst_valid = 1'b0;
    @(negedge clk);
    chk("w64_req_we_1", {bus64.mem_req, bus64.mem_we}, 2'b11);
    chk("w64_addr_1", bus64.mem_addr, 32'h0000_00F0);
    chk("w64_wdata_1", bus64.mem_wdata, {rf[4], ~rf[4]});
    @(negedge clk);
    chk("w64_req_we_2", {bus64.mem_req, bus64.mem_we}, 2'b11);
    chk("w64_addr_2", bus64.mem_addr, 32'h0000_00F8);
    chk("w64_wdata_2", bus64.mem_wdata, {rf[7], ~rf[7]});
    @(negedge clk);
    chk("w64_done", {bus64.done, bus64.sp_wr_en, bus64.mem_req}, 3'b110);
    chk("w64_sp_wr_data", bus64.sp_wr_data, 32'h0000_00F0);
    @(negedge clk);
    chk("w64_ready", bus64.inst_ready, 1);

    // Randomized mix with random ack stalls and ignored traffic while busy
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      inst = 16'($urandom);
      if (kind < 4)      inst[15:9] = 7'b1011010;
      else if (kind < 8) inst[15:9] = 7'b1011110;
      else if (kind == 8) begin
        inst[15:9] = ($urandom_range(0, 1) != 0) ? 7'b1011010 : 7'b1011110;
        inst[7:0]  = 8'h00;
      end else begin
        inst[15:12] = 4'h2;
      end
      case ($urandom_range(0, 3))
        0:       sp = 32'($urandom_range(0, 3) * 4);
        1:       sp = 32'hFFFF_FFF0;
        default: sp = $urandom & 32'hFFFF_FFFC;
      endcase
      case ($urandom_range(0, 2))
        0:       ack_pct = 100;
        1:       ack_pct = 60;
        default: ack_pct = 30;
      endcase
      issue(inst, sp, ack_pct == 100, 0, 1);
    end

    ack_pct = 100;
    repeat (4) @(negedge clk);
    chk("mem_queue_drained", 64'(exp_mem.size()), 0);
    chk("reg_queue_drained", 64'(exp_reg.size()), 0);
    chk("sp_queue_drained", 64'(exp_sp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
